// File: rtl/clock_set_controller_if.sv
// Signal bundle for the clock-setting controller: time strobe, buttons in;
// time, display blanking and mode out.
interface clock_set_controller_if;
  logic       tick_1s;
  logic       btn_mode;
  logic       btn_inc;
  logic [6:0] minutes;
  logic [5:0] hours;
  logic [5:0] seconds;
  logic       blank_hours;
  logic       blank_minutes;
  logic [1:0] mode;

  modport master (
    output tick_1s, btn_mode, btn_inc,
    input  minutes, hours, seconds, blank_hours, blank_minutes, mode
  );

  modport slave (
    input  tick_1s, btn_mode, btn_inc,
    output minutes, hours, seconds, blank_hours, blank_minutes, mode
  );
endinterface

// File: rtl/clock_set_controller.sv
// 24-hour clock with a RUN / SET_HOUR / SET_MIN editing FSM, synchronized
// single-shot buttons and a blinking display of the field being edited.
module clock_set_controller #(
  parameter int BLINK_HALF = 25000000
) (
  input logic                   clk,
  input logic                   reset,
  clock_set_controller_if.slave bus
);
  localparam int CW = $clog2(BLINK_HALF);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [5:0]    seconds_reg, seconds_next;
  logic [6:0]    minutes_reg, minutes_next;
  logic [5:0]    hours_reg, hours_next;
  logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_phase_reg, blink_phase_next;

  // Bit 0 = mode button, bit 1 = increment button.
  logic [1:0] btn_raw;
  logic [1:0] sync1_reg, sync2_reg, prev_reg;
  logic [2:0] settle_reg;
  logic [1:0] btn_ev;
  logic       mode_ev, inc_ev;

  assign btn_raw = {bus.btn_inc, bus.btn_mode};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      prev_reg   <= '0;
      settle_reg <= '0;
    end else begin
      sync1_reg  <= btn_raw;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
      settle_reg <= {settle_reg[1:0], 1'b1};
    end
  end

  // Edges are suppressed until prev_reg holds a real post-reset sample, so a
  // button held through reset must be released before it can fire.
  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    assign btn_ev[gi] = settle_reg[2] & sync2_reg[gi] & ~prev_reg[gi];
  end

  assign mode_ev = btn_ev[0];
  assign inc_ev  = btn_ev[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      seconds_reg     <= '0;
      minutes_reg     <= '0;
      hours_reg       <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      seconds_reg     <= seconds_next;
      minutes_reg     <= minutes_next;
      hours_reg       <= hours_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    seconds_next     = seconds_reg;
    minutes_next     = minutes_reg;
    hours_next       = hours_reg;
    blink_cnt_next   = blink_cnt_reg + 1'b1;
    blink_phase_next = blink_phase_reg;

    if (blink_cnt_reg == CW'(BLINK_HALF - 1)) begin
      blink_cnt_next   = '0;
      blink_phase_next = ~blink_phase_reg;
    end

    case (state_reg)
      RUN: begin
        // A coincident tick still lands on the edge that leaves RUN.
        if (bus.tick_1s) begin
          if (seconds_reg == 6'd59) begin
            seconds_next = '0;
            if (minutes_reg == 7'd59) begin
              minutes_next = '0;
              hours_next   = (hours_reg == 6'd23) ? 6'd0 : hours_reg + 6'd1;
            end else begin
              minutes_next = minutes_reg + 7'd1;
            end
          end else begin
            seconds_next = seconds_reg + 6'd1;
          end
        end
        if (mode_ev) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_ev)     state_next = SET_MIN;
        else if (inc_ev) hours_next = (hours_reg == 6'd23) ? 6'd0 : hours_reg + 6'd1;
      end
      SET_MIN: begin
        if (mode_ev) begin
          state_next   = RUN;
          seconds_next = '0;
        end else if (inc_ev) begin
          minutes_next = (minutes_reg == 7'd59) ? 7'd0 : minutes_reg + 7'd1;
        end
      end
      default: state_next = RUN;
    endcase

    if (mode_ev) begin
      blink_cnt_next   = '0;
      blink_phase_next = 1'b0;
    end
  end

  assign bus.mode          = state_reg;
  assign bus.seconds       = seconds_reg;
  assign bus.minutes       = minutes_reg;
  assign bus.hours         = hours_reg;
  assign bus.blank_hours   = (state_reg == SET_HOUR) && blink_phase_reg;
  assign bus.blank_minutes = (state_reg == SET_MIN) && blink_phase_reg;
endmodule
